// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: default line timing, frame width and FSM states.
package uart_pkg;

  localparam int unsigned DefaultClkFreq  = 50_000_000;
  localparam int unsigned DefaultBaudRate = 9600;
  localparam int unsigned DataBits        = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset level.
module sync_2ff #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= ResetValue;
      q    <= ResetValue;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver, 8N1 LSB first; defining UART_PARITY_EN switches the frame to 8E1.
// Emits one-cycle strobes for a good byte, a low stop bit, or a parity mismatch.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DefaultClkFreq,
  parameter int unsigned BAUD_RATE    = DefaultBaudRate,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  output logic [DataBits-1:0] data,
  output logic                new_data,
  output logic                busy,
  output logic                framing_error,
  output logic                parity_error
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IdxLast  = 3'(DataBits - 1);

  logic                rx_s;
  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          idx_q;
  logic [DataBits-1:0] shift_q;
`ifdef UART_PARITY_EN
  logic                par_q;
`endif

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data          <= '0;
      new_data      <= 1'b0;
      busy          <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_PARITY_EN
      par_q         <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      new_data      <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          busy  <= 1'b0;
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= StStart;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            idx_q <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            if (rx_s) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == IdxLast) begin
`ifdef UART_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        StParity: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            par_q   <= rx_s;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            // A low stop bit outranks a parity mismatch.
            if (!rx_s) begin
              framing_error <= 1'b1;
              state_q       <= StWaitIdle;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
`ifdef UART_PARITY_EN
              if (^{shift_q, par_q}) begin
                parity_error <= 1'b1;
              end else begin
                data     <= shift_q;
                new_data <= 1'b1;
              end
`else
              data     <= shift_q;
              new_data <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitIdle: begin
          if (rx_s) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random frames against a
// frame-level model that predicts the cycle and kind of every strobe.
module tb_uart_rx_byte;

  localparam int Cpb = 16;
`ifdef UART_PARITY_EN
  localparam int BitsAfterStart = 10;
`else
  localparam int BitsAfterStart = 9;
`endif
  // Falling edge -> 2 sync flops -> 1 detect -> half a bit -> remaining bits to mid stop.
  localparam int Lat = 3 + Cpb / 2 + BitsAfterStart * Cpb;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       new_data, busy, framing_error, parity_error;

  uart_rx_byte #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .new_data     (new_data),
    .busy         (busy),
    .framing_error(framing_error),
    .parity_error (parity_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int nd_count = 0;
  int last_event = 0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] exp_nd[int];
  bit         exp_fe[int];
  bit         exp_pe[int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of strobes and held data against the model.
  always @(negedge clock) begin
    bit e_nd, e_fe, e_pe;
    if (reset) begin
      model_data = 8'h00;
      e_nd = 1'b0;
      e_fe = 1'b0;
      e_pe = 1'b0;
    end else begin
      e_nd = exp_nd.exists(cyc);
      if (e_nd) model_data = exp_nd[cyc];
      e_fe = exp_fe.exists(cyc);
      e_pe = exp_pe.exists(cyc);
    end
    check("new_data", new_data, e_nd);
    check("framing_error", framing_error, e_fe);
    check("parity_error", parity_error, e_pe);
    check("data", data, model_data);
    if (new_data) nd_count++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives one frame; on a bad stop bit rx is left low for extra_low more cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int extra_low);
    int e;
    bit p_ok;
`ifdef UART_PARITY_EN
    p_ok = par_ok;
`else
    p_ok = 1'b1;
`endif
    e = cyc + Lat;
    last_event = e;
    if (!stop_ok) exp_fe[e] = 1'b1;
    else if (!p_ok) exp_pe[e] = 1'b1;
    else exp_nd[e] = b;
    rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(Cpb);
    end
`ifdef UART_PARITY_EN
    rx = p_ok ? ^b : ~(^b);
    tick(Cpb);
`endif
    rx = stop_ok;
    tick(Cpb);
    if (!stop_ok) tick(extra_low);
  endtask

  initial begin
    int n0;
    logic [7:0] b;
    bit s_ok, p_ok;
    reset = 1'b1;
    tick(3);
    check("reset_data", data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_new_data", new_data, 1'b0);
    reset = 1'b0;
    tick(5);

    // Single good frame.
    n0 = nd_count;
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("a5_data", data, 8'hA5);
    check("a5_busy_after", busy, 1'b0);
    check("a5_pulses", nd_count - n0, 1);
    tick(10);

    // Start-bit glitch.
    rx = 1'b0;
    tick(4);
    check("glitch_busy_high", busy, 1'b1);
    rx = 1'b1;
    tick(10);
    check("glitch_busy_low", busy, 1'b0);
    tick(10);

    // Bad stop bit, line held low for three more bits.
    send_frame(8'h3C, 1'b0, 1'b1, 3 * Cpb);
    check("wait_idle_busy", busy, 1'b1);
    check("fe_data_kept", data, 8'hA5);
    rx = 1'b1;
    tick(2 * Cpb);
    check("fe_busy_low", busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    check("5a_data", data, 8'h5A);
    tick(5);

    // Back-to-back frames.
    n0 = nd_count;
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'h02, 1'b1, 1'b1, 0);
    tick(2);
    check("b2b_pulses", nd_count - n0, 2);
    check("b2b_data", data, 8'h02);
    tick(10);

    // Reset in the middle of data bit 4 of 0xFF.
    rx = 1'b0;
    tick(Cpb);
    rx = 1'b1;
    tick(4 * Cpb + Cpb / 2);
    #2 reset = 1'b1;
    #1;
    check("abort_data", data, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_new_data", new_data, 1'b0);
    tick(3);
    reset = 1'b0;
    tick(5);
    send_frame(8'h81, 1'b1, 1'b1, 0);
    check("81_data", data, 8'h81);
    tick(5);

`ifdef UART_PARITY_EN
    n0 = nd_count;
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("par_good_data", data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("par_bad_pulses", nd_count - n0, 1);
    tick(5);
`endif

    // Random frames with random gaps, bad stop bits and bad parity.
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      s_ok = ($urandom_range(4) != 0);
      p_ok = ($urandom_range(4) != 0);
      send_frame(b, s_ok, p_ok, s_ok ? 0 : $urandom_range(2 * Cpb));
      if (!s_ok) begin
        rx = 1'b1;
        tick($urandom_range(30, 1));
      end else begin
        tick($urandom_range(30, 0));
      end
    end

    tick(20);
    check("events_drained", last_event < cyc, 1'b1);
    check("total_pulses", nd_count, exp_nd.num());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Asynchronous serial receiver: 8N1 by default, LSB first, idle-high line. Deserialises one frame into a byte and emits a one-cycle new_data strobe with the byte held stable on data. Sits directly upstream of the two-byte command buffer, which consumes the data/new_data pair. Rejects glitch starts and malformed stop bits, so the downstream buffer never sees a bad byte.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bit/s.
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE, clock cycles per bit (derived, overridable for simulation); must be >= 4.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
rx  input  1  serial line, asynchronous to clock, idle high.
data  output  8  last correctly received byte; held until the next good frame.
new_data  output  1  one-cycle strobe: data valid and updated this cycle.
busy  output  1  high from start-bit detection until return to IDLE.
framing_error  output  1  one-cycle strobe: stop bit sampled low.
parity_error  output  1  one-cycle strobe on parity mismatch; constant 0 without UART_PARITY_EN.

Behaviour:
- Reset is asynchronous, active-high; clock is clock. On reset: data=0x00, new_data=0, busy=0, framing_error=0, parity_error=0, state=IDLE, bit counter=0, cycle counter=0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rx_s.
- Cycle counter width: $clog2(CLKS_PER_BIT). Bit index: 3 bits.
- IDLE: busy=0. When rx_s==0, go to START, clear the cycle counter, set busy=1.
- START: count to CLKS_PER_BIT/2-1 (mid start bit). If rx_s==0 then, go to DATA with counter cleared. If rx_s==1, treat as a glitch: return to IDLE with no strobe.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[idx], LSB first. After idx 7, go to PARITY if enabled, else STOP.
- STOP: after CLKS_PER_BIT cycles (mid stop bit), sample rx_s.
  - If 1 and no parity error: next cycle data<=shift, new_data=1 for exactly one cycle, go to IDLE.
  - If 0: framing_error=1 for one cycle, data unchanged, no new_data, go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s==1 (break/line-low condition), then go to IDLE. busy stays 1.
- Latency: new_data rises 2 cycles (synchroniser) + approximately 9.5*CLKS_PER_BIT cycles after the rx falling edge (10.5 bit periods with parity).
- Back-to-back frames: a start bit arriving immediately after the stop-bit midpoint must be caught, because IDLE is re-entered before the stop bit ends.
- new_data and framing_error are mutually exclusive. Strobes never last more than 1 cycle.
- Reset mid-frame: the frame is abandoned and outputs return to reset values. Reception resumes on the next falling edge after reset deasserts.
- Unused state encodings go to IDLE with strobes low.

Optional Feature:
UART_PARITY_EN.
- Defined: frame is 8E1. PARITY state samples a 9th bit at mid-bit. Even parity is checked (XOR of 8 data bits and the parity bit must be 0). A mismatch, with a good stop bit, gives parity_error=1 for one cycle, no new_data, data unchanged. A bad stop bit takes priority: only framing_error pulses.
- Undefined: no PARITY state, 8N1 frame, parity_error tied 0.

Decomposition:
- Package uart_pkg: state encodings (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE), default CLK_FREQ/BAUD_RATE, DATA_BITS=8.
- One sub-module: sync_2ff, a 2-flop synchroniser with a reset value parameter (here 1). It is reusable for other async inputs.

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5 8N1 -> new_data one-cycle pulse at about 154 cycles after the falling edge; data=0xA5; busy low afterwards; no error strobes.
- Pull rx low 4 cycles then high -> no new_data, no framing_error; busy returns 0 within 10 cycles.
- Send 0x3C with stop bit 0, held low 3 extra bits -> single framing_error pulse; data stays 0xA5; IDLE only after rx returns high; then 0x5A received correctly.
- Send 0x01 and 0x02 back-to-back with no idle gap -> exactly two new_data pulses, data 0x01 then 0x02.
- Assert reset mid data bit 4 of 0xFF -> all outputs 0 asynchronously; after release, 0x81 is received as 0x81.
- With UART_PARITY_EN: 0x07 with parity 1 -> new_data, data=0x07. 0x07 with parity 0 -> parity_error pulse, no new_data.
